// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: default field widths and A/D channel opcodes.
package tl_ul_pkg;

    localparam int unsigned TL_AW   = 64;
    localparam int unsigned TL_DW   = 64;
    localparam int unsigned TL_SZW  = 8;
    localparam int unsigned TL_SRCW = 3;
    localparam int unsigned TL_OPW  = 3;
    localparam int unsigned TL_PW   = 3;

    typedef enum logic [2:0] {
        PUT_FULL_DATA_A    = 3'd0,
        PUT_PARTIAL_DATA_A = 3'd1,
        ARITHMETIC_DATA_A  = 3'd2,
        LOGICAL_DATA_A     = 3'd3,
        GET_A              = 3'd4,
        INTENT_A           = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK_D      = 3'd0,
        ACCESS_ACK_DATA_D = 3'd1,
        HINT_ACK_D        = 3'd2
    } tl_d_op_e;

endpackage

// File: rtl/tl_ul_a_fifo_if.sv
// TileLink-UL A-channel bundle; master drives valid and fields, slave drives ready.
interface tl_ul_a_fifo_if
    import tl_ul_pkg::*;
#(
    parameter int unsigned TL_ADDR_WIDTH   = TL_AW,
    parameter int unsigned TL_DATA_WIDTH   = TL_DW,
    parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int unsigned TL_SOURCE_WIDTH = TL_SRCW,
    parameter int unsigned TL_OPCODE_WIDTH = TL_OPW,
    parameter int unsigned TL_PARAM_WIDTH  = TL_PW,
    parameter int unsigned TL_SIZE_WIDTH   = TL_SZW
) ();

    logic                       valid;
    logic                       ready;
    logic [TL_OPCODE_WIDTH-1:0] opcode;
    logic [TL_PARAM_WIDTH-1:0]  param;
    logic [TL_ADDR_WIDTH-1:0]   address;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_STRB_WIDTH-1:0]   mask;
    logic [TL_DATA_WIDTH-1:0]   data;
    logic [TL_SOURCE_WIDTH-1:0] source;

    modport master (
        output valid, opcode, param, address, size, mask, data, source,
        input  ready
    );

    modport slave (
        input  valid, opcode, param, address, size, mask, data, source,
        output ready
    );

endinterface

// File: rtl/tl_ul_fifo_mem.sv
// FIFO storage array with modulo-DEPTH write and read pointers; read data is the head entry.
module tl_ul_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage is deliberately not reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/tl_ul_a_fifo.sv
// TL-UL A-channel FIFO: stores legal UL opcodes, drops and counts the rest.
module tl_ul_a_fifo
    import tl_ul_pkg::*;
#(
    parameter int unsigned TL_ADDR_WIDTH   = TL_AW,
    parameter int unsigned TL_DATA_WIDTH   = TL_DW,
    parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int unsigned TL_SOURCE_WIDTH = TL_SRCW,
    parameter int unsigned TL_OPCODE_WIDTH = TL_OPW,
    parameter int unsigned TL_PARAM_WIDTH  = TL_PW,
    parameter int unsigned TL_SIZE_WIDTH   = TL_SZW,
    parameter int unsigned DEPTH           = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    tl_ul_a_fifo_if.slave          s_a,
    tl_ul_a_fifo_if.master         m_a,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_pulse,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned W  = TL_OPCODE_WIDTH + TL_PARAM_WIDTH + TL_ADDR_WIDTH
                               + TL_SIZE_WIDTH + TL_STRB_WIDTH + TL_DATA_WIDTH
                               + TL_SOURCE_WIDTH;

    logic [CW-1:0] r_count;
    logic          r_drop_pulse;
    logic [7:0]    r_drop_cnt;

    logic          w_legal;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_store;
    logic          w_drop;
    logic          w_pop;
    logic [W-1:0]  w_wr_data;
    logic [W-1:0]  w_rd_data;

    assign w_legal = (s_a.opcode == TL_OPCODE_WIDTH'(PUT_FULL_DATA_A))
                  || (s_a.opcode == TL_OPCODE_WIDTH'(PUT_PARTIAL_DATA_A))
                  || (s_a.opcode == TL_OPCODE_WIDTH'(GET_A));

    // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = s_a.valid && !w_full;
    assign w_store = w_push && w_legal;
    assign w_drop  = w_push && !w_legal;
    assign w_pop   = !w_empty && m_a.ready;

    assign s_a.ready = !w_full;

    assign w_wr_data = {s_a.opcode, s_a.param, s_a.address, s_a.size,
                        s_a.mask, s_a.data, s_a.source};

    tl_ul_fifo_mem #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_store),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data)
    );

    assign m_a.valid = !w_empty;
    assign {m_a.opcode, m_a.param, m_a.address, m_a.size,
            m_a.mask, m_a.data, m_a.source} = w_empty ? '0 : w_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign count      = r_count;
    assign drop_pulse = r_drop_pulse;
    assign drop_cnt   = r_drop_cnt;

endmodule
